// File: rtl/ureg_pkg.sv
// Shared constants for the universal register: mode encodings and the mode field width.
package ureg_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b101;
    localparam logic [MODE_W-1:0] MODE_INC  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_DEC  = 3'b111;

endpackage

// File: rtl/universal_register_if.sv
// Operation/data bus of the universal register; master drives controls, slave returns register state.
interface ureg_if import ureg_pkg::*; #(
    parameter int WIDTH = 8
) ();
    logic                enable;
    logic [MODE_W-1:0]   mode;
    logic [WIDTH-1:0]    D;
    logic                sin_right;
    logic                sin_left;
    logic [WIDTH-1:0]    Q;
    logic [WIDTH-1:0]    QNot;
    logic                sout_right;
    logic                sout_left;
    logic                carry;
    logic                zero;

    modport master (
        output enable, mode, D, sin_right, sin_left,
        input  Q, QNot, sout_right, sout_left, carry, zero
    );

    modport slave (
        input  enable, mode, D, sin_right, sin_left,
        output Q, QNot, sout_right, sout_left, carry, zero
    );
endinterface

// File: rtl/ureg_next.sv
// Combinational next-state logic: given the current register and carry, computes the
// next value and next carry for the selected mode.
module ureg_next import ureg_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]  i_q,
    input  logic              i_carry,
    input  logic [MODE_W-1:0] i_mode,
    input  logic [WIDTH-1:0]  i_d,
    input  logic              i_sin_right,
    input  logic              i_sin_left,
    output logic [WIDTH-1:0]  o_next_q,
    output logic              o_next_carry
);
    logic [WIDTH:0]   w_inc;
    logic [WIDTH-1:0] w_dec;

    // The extra bit of the increment is the wrap-around carry.
    assign w_inc = {1'b0, i_q} + (WIDTH+1)'(1);
    assign w_dec = i_q - WIDTH'(1);

    always_comb begin
        o_next_q     = i_q;
        o_next_carry = i_carry;
        case (i_mode)
            MODE_SHR: begin
                o_next_q     = {i_sin_right, i_q[WIDTH-1:1]};
                o_next_carry = i_q[0];
            end
            MODE_SHL: begin
                o_next_q     = {i_q[WIDTH-2:0], i_sin_left};
                o_next_carry = i_q[WIDTH-1];
            end
            MODE_ROR: begin
                o_next_q     = {i_q[0], i_q[WIDTH-1:1]};
                o_next_carry = i_q[0];
            end
            MODE_ROL: begin
                o_next_q     = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
                o_next_carry = i_q[WIDTH-1];
            end
            MODE_LOAD: begin
                o_next_q     = i_d;
                o_next_carry = 1'b0;
            end
            MODE_INC: begin
                o_next_q     = w_inc[WIDTH-1:0];
                o_next_carry = w_inc[WIDTH];
            end
            MODE_DEC: begin
                o_next_q     = w_dec;
                o_next_carry = (i_q == '0);
            end
            default: begin
                o_next_q     = i_q;
                o_next_carry = i_carry;
            end
        endcase
    end
endmodule

// File: rtl/universal_register.sv
// WIDTH-bit storage/shift/count register with synchronous clear and preset, enable,
// and eight modes; true/complement, serial and flag outputs decode from the register.
module universal_register import ureg_pkg::*; #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] PRESET_VALUE = {WIDTH{1'b1}}
) (
    input  logic  clk,
    input  logic  clear,
    input  logic  preset,
    ureg_if.slave bus
);
    logic [WIDTH-1:0] r_q;
    logic             r_carry;
    logic [WIDTH-1:0] w_next_q;
    logic             w_next_carry;

    ureg_next #(.WIDTH(WIDTH)) u_next (
        .i_q          (r_q),
        .i_carry      (r_carry),
        .i_mode       (bus.mode),
        .i_d          (bus.D),
        .i_sin_right  (bus.sin_right),
        .i_sin_left   (bus.sin_left),
        .o_next_q     (w_next_q),
        .o_next_carry (w_next_carry)
    );

    // clear beats preset, and both override enable and mode on the same edge.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_q     <= '0;
            r_carry <= 1'b0;
        end else if (preset) begin
            r_q     <= PRESET_VALUE;
            r_carry <= 1'b0;
        end else if (bus.enable) begin
            r_q     <= w_next_q;
            r_carry <= w_next_carry;
        end
    end

    assign bus.Q          = r_q;
    assign bus.QNot       = ~r_q;
    assign bus.sout_right = r_q[0];
    assign bus.sout_left  = r_q[WIDTH-1];
    assign bus.carry      = r_carry;
    assign bus.zero       = (r_q == '0);
endmodule

// File: tb/tb_universal_register.sv
// Self-checking bench for universal_register (WIDTH=8): directed plan steps followed by
// random operations, each edge compared against an arithmetic reference model.
module tb_universal_register;
    import ureg_pkg::*;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic clk;
    logic clear;
    logic preset;
    int   n_checks;
    int   n_fail;
    int   m_q;
    int   m_c;

    ureg_if #(.WIDTH(W)) u_bus ();

    universal_register #(.WIDTH(W)) dut (
        .clk    (clk),
        .clear  (clear),
        .preset (preset),
        .bus    (u_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".Q"},     32'(u_bus.Q),          32'(m_q));
        check({tag, ".QNot"},  32'(u_bus.QNot),       32'((~m_q) & MASK));
        check({tag, ".soutR"}, 32'(u_bus.sout_right), 32'(m_q % 2));
        check({tag, ".soutL"}, 32'(u_bus.sout_left),  32'(m_q / (1 << (W-1))));
        check({tag, ".carry"}, 32'(u_bus.carry),      32'(m_c));
        check({tag, ".zero"},  32'(u_bus.zero),       32'(m_q == 0));
    endtask

    // Reference: the operation rules written as integer arithmetic on the register value.
    task automatic model(input bit clr, input bit pre, input bit en, input int mode,
                         input int d, input bit sr, input bit sl);
        int top;
        top = 1 << (W-1);
        if (clr) begin
            m_q = 0; m_c = 0;
        end else if (pre) begin
            m_q = MASK; m_c = 0;
        end else if (en) begin
            case (mode)
                1: begin m_c = m_q % 2;   m_q = m_q / 2 + sr * top; end
                2: begin m_c = m_q / top; m_q = (m_q * 2 + sl) % (MASK + 1); end
                3: begin m_c = m_q % 2;   m_q = m_q / 2 + (m_q % 2) * top; end
                4: begin m_c = m_q / top; m_q = (m_q * 2 + m_q / top) % (MASK + 1); end
                5: begin m_q = d & MASK;  m_c = 0; end
                6: begin m_c = (m_q == MASK); m_q = (m_q + 1) % (MASK + 1); end
                7: begin m_c = (m_q == 0);    m_q = (m_q + MASK) % (MASK + 1); end
                default: ;
            endcase
        end
    endtask

    task automatic step(input string tag, input bit clr, input bit pre, input bit en,
                        input int mode, input int d, input bit sr, input bit sl);
        clear           = clr;
        preset          = pre;
        u_bus.enable    = en;
        u_bus.mode      = MODE_W'(mode);
        u_bus.D         = W'(d);
        u_bus.sin_right = sr;
        u_bus.sin_left  = sl;
        model(clr, pre, en, mode, d, sr, sl);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_q      = 0;
        m_c      = 0;
        clear = 1'b0; preset = 1'b0;
        u_bus.enable = 1'b0; u_bus.mode = MODE_HOLD; u_bus.D = '0;
        u_bus.sin_right = 1'b0; u_bus.sin_left = 1'b0;
        #2;

        // Reset and preset
        step("reset", 1, 0, 0, 0, 8'h00, 0, 0);
        check("reset.Q_const", 32'(u_bus.Q), 32'h00);
        check("reset.QNot_const", 32'(u_bus.QNot), 32'hFF);
        step("preset", 0, 1, 1, 3, 8'h00, 0, 0);
        check("preset.Q_const", 32'(u_bus.Q), 32'hFF);
        step("clr_pre", 1, 1, 1, 6, 8'h00, 0, 0);
        check("clr_pre.Q_const", 32'(u_bus.Q), 32'h00);

        // Load and hold via enable=0
        step("load_a5", 0, 0, 1, 5, 8'hA5, 1, 1);
        check("load.QNot_const", 32'(u_bus.QNot), 32'h5A);
        for (int i = 0; i < 3; i++) step("en_off", 0, 0, 0, 1, 8'h00, 1, 1);
        check("hold.Q_const", 32'(u_bus.Q), 32'hA5);
        step("mode_hold", 0, 0, 1, 0, 8'h3C, 1, 1);

        // Shifts
        step("shr", 0, 0, 1, 1, 8'h00, 1, 1);
        check("shr.Q_const", 32'(u_bus.Q), 32'hD2);
        step("shl", 0, 0, 1, 2, 8'h00, 1, 0);
        check("shl.Q_const", 32'(u_bus.Q), 32'hA4);
        check("shl.carry_const", 32'(u_bus.carry), 32'h1);

        // Rotates (serial inputs must be ignored)
        step("load_81", 0, 0, 1, 5, 8'h81, 0, 0);
        step("ror", 0, 0, 1, 3, 8'h00, 0, 0);
        check("ror.Q_const", 32'(u_bus.Q), 32'hC0);
        step("rol1", 0, 0, 1, 4, 8'h00, 0, 0);
        step("rol2", 0, 0, 1, 4, 8'h00, 0, 0);
        check("rol2.Q_const", 32'(u_bus.Q), 32'h03);

        // Count wrap
        step("load_fe", 0, 0, 1, 5, 8'hFE, 0, 0);
        step("inc1", 0, 0, 1, 6, 8'h00, 0, 0);
        step("inc2", 0, 0, 1, 6, 8'h00, 0, 0);
        check("inc2.zero_const", 32'(u_bus.zero), 32'h1);
        check("inc2.carry_const", 32'(u_bus.carry), 32'h1);
        step("dec", 0, 0, 1, 7, 8'h00, 0, 0);
        check("dec.Q_const", 32'(u_bus.Q), 32'hFF);

        // Mid-operation clear
        step("load_10", 0, 0, 1, 5, 8'h10, 0, 0);
        step("inc_a", 0, 0, 1, 6, 8'h00, 0, 0);
        step("inc_b", 0, 0, 1, 6, 8'h00, 0, 0);
        check("mid.before_const", 32'(u_bus.Q), 32'h12);
        step("inc_clr", 1, 0, 1, 6, 8'h00, 0, 0);
        step("inc_resume", 0, 0, 1, 6, 8'h00, 0, 0);
        check("mid.resume_const", 32'(u_bus.Q), 32'h01);

        // Random operations
        for (int i = 0; i < 300; i++) begin
            step("rand",
                 ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
